inst_encode: RTL

Streaming RV32I instruction encoder: accepts decoded instruction fields (type, opcode, register addresses, funct fields, 32-bit immediate) over a valid/ready handshake and packs them into 32-bit instruction words. It is the inverse of the instruction decoder. It sits between the test-program / boot-loader source and the instruction-memory write port, supplying each word with a sequential byte address. A small FIFO decouples the two sides, and error flags catch unencodable requests.

---
 rtl/inst_encode_if.sv | 35 +++
 rtl/inst_encode.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/inst_encode_if.sv
// Field-tuple input and encoded-word output bundle for inst_encode.
// ADDR_W must match the ADDR_W of the attached inst_encode instance.
interface inst_encode_if #(
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_type;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [7:0]        err_cnt;

    modport master (
        output in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_word, out_addr, out_err, err_cnt
    );

    modport slave (
        input  in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_word, out_addr, out_err, err_cnt
    );
endinterface

// File: rtl/inst_encode.sv
// RV32I field-to-word encoder with an addressed output FIFO.
// Optional macro ENCODE_IMM_CHECK_EN flags out-of-range or misaligned immediates.
module inst_encode #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 12,
    parameter int BASE_ADDR  = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    inst_encode_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [3:0] TYPE_INVALID = 4'd0;
    localparam logic [3:0] TYPE_R       = 4'd1;
    localparam logic [3:0] TYPE_I       = 4'd2;
    localparam logic [3:0] TYPE_S       = 4'd3;
    localparam logic [3:0] TYPE_B       = 4'd4;
    localparam logic [3:0] TYPE_U       = 4'd5;
    localparam logic [3:0] TYPE_J       = 4'd6;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef logic [PTR_W:0] ptr_t;

    logic [31:0]       imm;
    logic [31:0]       enc_word;
    logic              enc_err;

    ptr_t              wr_ptr;
    ptr_t              rd_ptr;
    ptr_t              wr_next;
    ptr_t              rd_next;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    logic [ADDR_W-1:0] addr_cnt;
    logic [7:0]        err_cnt;

    logic [31:0]       mem_word [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
    logic              mem_err  [FIFO_DEPTH];

    logic [31:0]       head_word;
    logic [ADDR_W-1:0] head_addr;
    logic              head_err;

    assign imm = bus.in_imm;

`ifdef ENCODE_IMM_CHECK_EN
    logic fit_12;
    logic fit_13;
    logic fit_21;

    // Sign-extension checks: the discarded upper bits must all match the kept sign bit.
    assign fit_12 = (&imm[31:11]) || !(|imm[31:11]);
    assign fit_13 = (&imm[31:12]) || !(|imm[31:12]);
    assign fit_21 = (&imm[31:20]) || !(|imm[31:20]);
`endif

    always_comb begin
        enc_word = 32'h0;
        enc_err  = 1'b0;
        case (bus.in_type)
            TYPE_R: begin
                enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            bus.in_rd, bus.in_opcode};
            end
            TYPE_I: begin
                enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
`ifdef ENCODE_IMM_CHECK_EN
                enc_err  = !fit_12;
`endif
            end
            TYPE_S: begin
                enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            imm[4:0], bus.in_opcode};
`ifdef ENCODE_IMM_CHECK_EN
                enc_err  = !fit_12;
`endif
            end
            TYPE_B: begin
                enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            imm[4:1], imm[11], bus.in_opcode};
`ifdef ENCODE_IMM_CHECK_EN
                enc_err  = !fit_13 || imm[0];
`endif
            end
            TYPE_U: begin
                enc_word = {imm[31:12], bus.in_rd, bus.in_opcode};
`ifdef ENCODE_IMM_CHECK_EN
                enc_err  = |imm[11:0];
`endif
            end
            TYPE_J: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
`ifdef ENCODE_IMM_CHECK_EN
                enc_err  = !fit_21 || imm[0];
`endif
            end
            TYPE_INVALID: begin
                enc_word = 32'h0;
                enc_err  = 1'b1;
            end
            default: begin
                enc_word = 32'h0;
                enc_err  = 1'b1;
            end
        endcase
    end

    // Extra pointer bit distinguishes full from empty; start blocks both handshakes.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push    = bus.in_valid && !full && !start;
    assign pop     = bus.out_ready && !empty && !start;
    assign wr_next = wr_ptr + ptr_t'(push);
    assign rd_next = rd_ptr + ptr_t'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_word[wr_ptr[PTR_W-1:0]] <= enc_word;
            mem_addr[wr_ptr[PTR_W-1:0]] <= addr_cnt;
            mem_err[wr_ptr[PTR_W-1:0]]  <= enc_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            addr_cnt <= BASE;
            err_cnt  <= 8'd0;
        end else if (start) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            addr_cnt <= BASE;
            err_cnt  <= 8'd0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            if (push) begin
                addr_cnt <= addr_cnt + ADDR_W'(4);
                if (enc_err && (err_cnt != 8'hFF)) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

    // Registered head: loads the next head entry, taking the incoming word
    // directly when it becomes the head, and holds when the FIFO drains empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_word <= 32'h0;
            head_addr <= BASE;
            head_err  <= 1'b0;
        end else if (!start && (rd_next != wr_next)) begin
            if (rd_next == wr_ptr) begin
                head_word <= enc_word;
                head_addr <= addr_cnt;
                head_err  <= enc_err;
            end else begin
                head_word <= mem_word[rd_next[PTR_W-1:0]];
                head_addr <= mem_addr[rd_next[PTR_W-1:0]];
                head_err  <= mem_err[rd_next[PTR_W-1:0]];
            end
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_word  = head_word;
    assign bus.out_addr  = head_addr;
    assign bus.out_err   = head_err;
    assign bus.err_cnt   = err_cnt;

endmodule
